// File: rtl/reg_file_sweep.sv
// reg_file_sweep: parametrised multi-read-port register file with per-entry dirty tracking
// and a one-entry-per-cycle clear engine. Define REGFILE_BYPASS_EN for write-through reads.
module reg_file_sweep #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int NR = 2
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              WriteEn,
    input  logic [D-1:0]      Waddr,
    input  logic [W-1:0]      DataIn,
    input  logic [NR*D-1:0]   Raddr,
    output logic [NR*W-1:0]   DataOut,
    input  logic              Clear,
    output logic              Busy,
    output logic              Done,
    output logic [2**D-1:0]   DirtyMask
);

    localparam int N = 2 ** D;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [D-1:0] ptr;
    logic [W-1:0] regs [N];
    logic [N-1:0] dirty;
    logic         wr_ok;
    logic         sweep_step;
    logic         sweep_last;
    logic         busy_q;
    logic         done_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The write port is only honoured in IDLE; during a sweep the controller stalls on Busy.
    always_comb begin
        next_state = state;
        wr_ok      = 1'b0;
        sweep_step = 1'b0;
        sweep_last = 1'b0;
        case (state)
            IDLE: begin
                wr_ok = WriteEn;
                if (Clear) begin
                    next_state = SWEEP;
                end
            end
            SWEEP: begin
                sweep_step = 1'b1;
                sweep_last = (ptr == D'(N - 1));
                if (sweep_last) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Ptr rests at zero in IDLE so every sweep starts from entry 0 and wraps back on its last step.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            ptr <= '0;
        end else if (sweep_step) begin
            ptr <= ptr + D'(1);
        end else begin
            ptr <= '0;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (next_state == SWEEP);
            done_q <= sweep_last;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int k = 0; k < N; k++) begin
                regs[k] <= '0;
            end
        end else if (sweep_step) begin
            regs[ptr] <= '0;
        end else if (wr_ok) begin
            regs[Waddr] <= DataIn;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            dirty <= '0;
        end else if (sweep_step) begin
            dirty[ptr] <= 1'b0;
        end else if (wr_ok) begin
            dirty[Waddr] <= 1'b1;
        end
    end

    assign DirtyMask = dirty;

    // wr_ok is only ever high in IDLE, which keeps the bypass path dead during a sweep.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [D-1:0] addr;
        assign addr = Raddr[i*D +: D];
`ifdef REGFILE_BYPASS_EN
        assign DataOut[i*W +: W] = (wr_ok && (addr == Waddr)) ? DataIn : regs[addr];
`else
        assign DataOut[i*W +: W] = regs[addr];
`endif
    end

`ifndef SYNTHESIS
    a_busy_done_exclusive: assert property (@(posedge Clk) disable iff (!ResetN)
        !(Busy && Done));
    a_busy_tracks_state: assert property (@(posedge Clk) disable iff (!ResetN)
        Busy == (state == SWEEP));
`endif

endmodule
